// File: rtl/riscv_pkg.sv
// Shared constants and the ID/EX bundle for the 5-stage RISC-V core.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [6:0]        op;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } id_ex_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in EX and the sources in ID.
module load_use_detect
  import riscv_pkg::*;
#(
  parameter int REG_AW_P = REG_AW
) (
  input  logic              valid_e,
  input  logic [1:0]        result_src_e,
  input  logic [REG_AW_P-1:0] rd_e,
  input  logic [REG_AW_P-1:0] rs1_d,
  input  logic [REG_AW_P-1:0] rs2_d,
  output logic              lwstall
);

  logic is_load;
  logic rd_nz;
  logic hit;

  always_comb begin
    is_load = valid_e & (result_src_e == RES_MEM);
    rd_nz   = |rd_e;
    hit     = (rd_e == rs1_d) | (rd_e == rs2_d);
    lwstall = is_load & rd_nz & hit;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch/jump flush.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int REG_AW_P = REG_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_d,
  input  logic                reg_write_d,
  input  logic [1:0]          result_src_d,
  input  logic                mem_write_d,
  input  logic                jump_d,
  input  logic                branch_d,
  input  logic                alu_src_d,
  input  logic [1:0]          alu_op_d,
  input  logic [2:0]          funct3_d,
  input  logic [6:0]          funct7_d,
  input  logic [6:0]          op_d,
  input  logic [REG_AW_P-1:0] rs1_d,
  input  logic [REG_AW_P-1:0] rs2_d,
  input  logic [REG_AW_P-1:0] rd_d,
  input  logic [XLEN_P-1:0]   rd1_d,
  input  logic [XLEN_P-1:0]   rd2_d,
  input  logic [XLEN_P-1:0]   imm_d,
  input  logic [XLEN_P-1:0]   pc_d,
  input  logic [XLEN_P-1:0]   pc_plus4_d,
  input  logic                flush_e_i,
  output logic                valid_e,
  output logic                reg_write_e,
  output logic [1:0]          result_src_e,
  output logic                mem_write_e,
  output logic                jump_e,
  output logic                branch_e,
  output logic                alu_src_e,
  output logic [1:0]          alu_op_e,
  output logic [2:0]          funct3_e,
  output logic [6:0]          funct7_e,
  output logic [6:0]          op_e,
  output logic [REG_AW_P-1:0] rs1_e,
  output logic [REG_AW_P-1:0] rs2_e,
  output logic [REG_AW_P-1:0] rd_e,
  output logic [XLEN_P-1:0]   rd1_e,
  output logic [XLEN_P-1:0]   rd2_e,
  output logic [XLEN_P-1:0]   imm_e,
  output logic [XLEN_P-1:0]   pc_e,
  output logic [XLEN_P-1:0]   pc_plus4_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                bubble_o
);

  id_ex_t ex_d;
  id_ex_t ex_q;
  logic   lwstall;

  load_use_detect #(.REG_AW_P(REG_AW_P)) u_lud (
    .valid_e      (ex_q.valid),
    .result_src_e (ex_q.result_src),
    .rd_e         (ex_q.rd),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .lwstall      (lwstall)
  );

  // a flush kills the dependent instr, so no need to hold F/D
  always_comb begin
    stall_f  = lwstall & ~flush_e_i;
    stall_d  = lwstall & ~flush_e_i;
    bubble_o = lwstall | flush_e_i;
  end

  // bubbles only clear control; datapath fields are don't-care once invalid
  always_comb begin
    ex_d = ex_q;
    if (bubble_o) begin
      ex_d.valid      = 1'b0;
      ex_d.reg_write  = 1'b0;
      ex_d.mem_write  = 1'b0;
      ex_d.jump       = 1'b0;
      ex_d.branch     = 1'b0;
      ex_d.result_src = RES_ALU;
    end else begin
      ex_d.valid      = valid_d;
      ex_d.reg_write  = reg_write_d;
      ex_d.result_src = result_src_d;
      ex_d.mem_write  = mem_write_d;
      ex_d.jump       = jump_d;
      ex_d.branch     = branch_d;
      ex_d.alu_src    = alu_src_d;
      ex_d.alu_op     = alu_op_d;
      ex_d.funct3     = funct3_d;
      ex_d.funct7     = funct7_d;
      ex_d.op         = op_d;
      ex_d.rs1        = rs1_d;
      ex_d.rs2        = rs2_d;
      ex_d.rd         = rd_d;
      ex_d.rd1        = rd1_d;
      ex_d.rd2        = rd2_d;
      ex_d.imm        = imm_d;
      ex_d.pc         = pc_d;
      ex_d.pc_plus4   = pc_plus4_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  always_comb begin
    valid_e      = ex_q.valid;
    reg_write_e  = ex_q.reg_write;
    result_src_e = ex_q.result_src;
    mem_write_e  = ex_q.mem_write;
    jump_e       = ex_q.jump;
    branch_e     = ex_q.branch;
    alu_src_e    = ex_q.alu_src;
    alu_op_e     = ex_q.alu_op;
    funct3_e     = ex_q.funct3;
    funct7_e     = ex_q.funct7;
    op_e         = ex_q.op;
    rs1_e        = ex_q.rs1;
    rs2_e        = ex_q.rs2;
    rd_e         = ex_q.rd;
    rd1_e        = ex_q.rd1;
    rd2_e        = ex_q.rd2;
    imm_e        = ex_q.imm;
    pc_e         = ex_q.pc;
    pc_plus4_e   = ex_q.pc_plus4;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use stall, flush, reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_d, reg_write_d, mem_write_d;
  logic        jump_d, branch_d, alu_src_d, flush_e_i;
  logic [1:0]  result_src_d, alu_op_d;
  logic [2:0]  funct3_d;
  logic [6:0]  funct7_d, op_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [31:0] rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d;

  logic        valid_e, reg_write_e, mem_write_e;
  logic        jump_e, branch_e, alu_src_e;
  logic [1:0]  result_src_e, alu_op_e;
  logic [2:0]  funct3_e;
  logic [6:0]  funct7_e, op_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic        stall_f, stall_d, bubble_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .valid_d(valid_d), .reg_write_d(reg_write_d),
    .result_src_d(result_src_d), .mem_write_d(mem_write_d),
    .jump_d(jump_d), .branch_d(branch_d), .alu_src_d(alu_src_d),
    .alu_op_d(alu_op_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
    .op_d(op_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .flush_e_i(flush_e_i),
    .valid_e(valid_e), .reg_write_e(reg_write_e),
    .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .alu_op_e(alu_op_e), .funct3_e(funct3_e), .funct7_e(funct7_e),
    .op_e(op_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_o(bubble_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // r-type / load shorthand: kind 0=R(add-like), 1=load
  task automatic drive(input bit ld, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rdx,
                       input logic [31:0] p);
    valid_d      = 1'b1;
    reg_write_d  = 1'b1;
    result_src_d = ld ? 2'b01 : 2'b00;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = ld;
    alu_op_d     = ld ? 2'b00 : 2'b10;
    funct3_d     = ld ? 3'b010 : f3;
    funct7_d     = f7;
    op_d         = ld ? 7'b0000011 : 7'b0110011;
    rs1_d        = r1;
    rs2_d        = r2;
    rd_d         = rdx;
    rd1_d        = 32'h1000_0000 + 32'(r1);
    rd2_d        = 32'h2000_0000 + 32'(r2);
    imm_d        = ld ? 32'h10 : 32'h0;
    pc_d         = p;
    pc_plus4_d   = p + 32'd4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    flush_e_i = 1'b0;
    reset     = 1'b0;
    drive(1'b0, 3'b0, 7'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    step();

    // 1: reset with random ID inputs
    valid_d = 1'b1; reg_write_d = 1'b1;
    result_src_d = 2'b01; alu_op_d = 2'($urandom);
    rd1_d = $urandom; pc_d = $urandom; rd_d = 5'($urandom);
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(valid_e), 0);
    chk("rst_aluop", 32'(alu_op_e), 0);
    chk("rst_rd1", rd1_e, 0);
    chk("rst_stall", 32'(stall_f), 0);
    step();
    chk("rst_hold_valid", 32'(valid_e), 0);
    chk("rst_hold_rsrc", 32'(result_src_e), 0);
    reset = 1'b0;

    // 2: add x5,x1,x2
    drive(1'b0, 3'b000, 7'b0, 5'd1, 5'd2, 5'd5, 32'h100);
    #1;
    chk("add_nostall", 32'(stall_f), 0);
    step();
    chk("add_valid", 32'(valid_e), 1);
    chk("add_op", 32'(op_e), 32'h33);
    chk("add_aluop", 32'(alu_op_e), 2);
    chk("add_f3", 32'(funct3_e), 0);
    chk("add_f7", 32'(funct7_e), 0);
    chk("add_rd", 32'(rd_e), 5);
    chk("add_rd1", rd1_e, 32'h1000_0001);
    chk("add_rd2", rd2_e, 32'h2000_0002);
    chk("add_pc4", pc_plus4_e, 32'h104);
    chk("add_rw", 32'(reg_write_e), 1);

    // 3: lw x5 then dependent add
    drive(1'b1, 3'b0, 7'b0, 5'd1, 5'd0, 5'd5, 32'h104);
    step();
    chk("lw_rsrc", 32'(result_src_e), 1);
    drive(1'b0, 3'b000, 7'b0, 5'd5, 5'd7, 5'd6, 32'h108);
    #1;
    chk("lu_stall_f", 32'(stall_f), 1);
    chk("lu_stall_d", 32'(stall_d), 1);
    chk("lu_bubble", 32'(bubble_o), 1);
    step();
    chk("lu_bub_valid", 32'(valid_e), 0);
    chk("lu_bub_rw", 32'(reg_write_e), 0);
    chk("lu_bub_rsrc", 32'(result_src_e), 0);
    chk("lu_bub_aluop", 32'(alu_op_e), 0);
    chk("lu_stall_gone", 32'(stall_f), 0);
    chk("lu_bubble_gone", 32'(bubble_o), 0);
    step();
    chk("lu_add_valid", 32'(valid_e), 1);
    chk("lu_add_rd", 32'(rd_e), 6);
    chk("lu_add_rs1", 32'(rs1_e), 5);

    // 4: lw x0 then add x6,x0,x7
    drive(1'b1, 3'b0, 7'b0, 5'd1, 5'd0, 5'd0, 32'h10c);
    step();
    drive(1'b0, 3'b000, 7'b0, 5'd0, 5'd7, 5'd6, 32'h110);
    #1;
    chk("x0_stall", 32'(stall_f), 0);
    chk("x0_bubble", 32'(bubble_o), 0);
    step();
    chk("x0_add_valid", 32'(valid_e), 1);
    chk("x0_add_pc", pc_e, 32'h110);

    // 5: load-use hazard coincident with flush
    drive(1'b1, 3'b0, 7'b0, 5'd1, 5'd0, 5'd5, 32'h114);
    step();
    drive(1'b0, 3'b000, 7'b0, 5'd7, 5'd5, 5'd6, 32'h118);
    flush_e_i = 1'b1;
    #1;
    chk("fl_lu_stall", 32'(stall_f), 0);
    chk("fl_lu_stall_d", 32'(stall_d), 0);
    chk("fl_lu_bubble", 32'(bubble_o), 1);
    step();
    chk("fl_lu_valid", 32'(valid_e), 0);

    // 6: flush with sub in ID, then normal capture
    drive(1'b0, 3'b000, 7'b0100000, 5'd3, 5'd4, 5'd8, 32'h200);
    flush_e_i = 1'b1;
    #1;
    chk("fl_sub_bubble", 32'(bubble_o), 1);
    step();
    chk("fl_sub_valid", 32'(valid_e), 0);
    chk("fl_sub_rw", 32'(reg_write_e), 0);
    flush_e_i = 1'b0;
    drive(1'b0, 3'b111, 7'b0, 5'd3, 5'd4, 5'd9, 32'h204);
    step();
    chk("post_fl_valid", 32'(valid_e), 1);
    chk("post_fl_rd", 32'(rd_e), 9);
    chk("post_fl_f3", 32'(funct3_e), 7);

    // reset asserted mid-stall
    drive(1'b1, 3'b0, 7'b0, 5'd1, 5'd0, 5'd5, 32'h208);
    step();
    drive(1'b0, 3'b000, 7'b0, 5'd5, 5'd7, 5'd6, 32'h20c);
    #1;
    chk("pre_rst_stall", 32'(stall_f), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall_f), 0);
    chk("mid_rst_bubble", 32'(bubble_o), 0);
    chk("mid_rst_valid", 32'(valid_e), 0);
    chk("mid_rst_rd", 32'(rd_e), 0);
    chk("mid_rst_pc4", pc_plus4_e, 0);
    step();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
